obuf_drain_ctrl: RTL and testbench

//  Drains computed output rows from the O buffer into a valid/ready activation stream for the writeback path.

---
 rtl/obuf_drain_ctrl_if.sv | 15 +
 rtl/obuf_drain_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_obuf_drain_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obuf_drain_ctrl_if.sv
// Output activation stream from the O buffer drain controller to the writeback path.
// One beat carries one row plus a per-column keep mask and an end-of-drain flag.
interface obuf_drain_ctrl_if #(
    parameter int unsigned ACT_WIDTH = 8,
    parameter int unsigned ARRAY_M   = 8
);
    logic [ACT_WIDTH*ARRAY_M-1:0] out_data;
    logic [ARRAY_M-1:0]           out_keep;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;

    modport master (output out_data, output out_keep, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_keep, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/obuf_drain_ctrl.sv
// Drains rows from the O buffer into a valid/ready activation stream.
// Reads are credit-limited so a 2-entry output FIFO absorbs the RAM read latency.
module obuf_drain_ctrl #(
    parameter int unsigned RAM_SIZE   = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned ARRAY_M    = 8,
    parameter int unsigned ACT_WIDTH  = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          num_rows,
    input  logic [$clog2(ARRAY_M):0]     num_cols,
    output logic [ADDR_WIDTH-1:0]        obuf_read_addr,
    input  logic [ACT_WIDTH*ARRAY_M-1:0] obuf_data,
    obuf_drain_ctrl_if.master            ostrm,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned DATA_W = ACT_WIDTH * ARRAY_M;
    localparam int unsigned COL_W  = $clog2(ARRAY_M) + 1;
    localparam int unsigned ROW_W  = ADDR_WIDTH + 1;
    localparam int unsigned CRED_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    accept, issue, issue_last;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ROW_W-1:0]        rows_total_q, rows_issued_q;
    logic [ARRAY_M-1:0]      keep_q, keep_d;
    logic [DATA_W-1:0]       col_mask;
    logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_last_q;
    logic [CRED_W-1:0]       inflight, credits;
    logic                    push, pop, push_last;
    logic [DATA_W-1:0]       push_data;
    logic                    head_vld_q, head_last_q, tail_vld_q, tail_last_q;
    logic [DATA_W-1:0]       head_data_q, tail_data_q;
    logic [ARRAY_M-1:0]      head_keep_q, tail_keep_q;

    assign pop       = head_vld_q & ostrm.out_ready;
    assign push      = pipe_vld_q[RD_LATENCY-1];
    assign push_last = pipe_last_q[RD_LATENCY-1];
    assign push_data = obuf_data & col_mask;

    // Keep mask for the requested column count, and its byte-expanded data mask
    always_comb begin
        keep_d   = '0;
        col_mask = '0;
        for (int m = 0; m < ARRAY_M; m++) begin
            keep_d[m] = (COL_W'(m) < num_cols);
            col_mask[m*ACT_WIDTH +: ACT_WIDTH] = {ACT_WIDTH{keep_q[m]}};
        end
    end

    // Reads issued but not yet captured, plus rows already buffered
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CRED_W'(pipe_vld_q[i]);
        end
        credits = CRED_W'(head_vld_q) + CRED_W'(tail_vld_q) + inflight;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_rows == '0) done_d  = 1'b1;
                    else                state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A pop this cycle frees one slot for the read issued now
                if (credits < (CRED_W'(2) + CRED_W'(pop))) begin
                    issue      = 1'b1;
                    issue_last = (rows_issued_q == (rows_total_q - ROW_W'(1)));
                    if (issue_last) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pop && head_last_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr_q     <= '0;
            rows_total_q  <= '0;
            rows_issued_q <= '0;
            keep_q        <= '0;
        end else if (accept) begin
            rd_addr_q     <= base_addr;
            rows_total_q  <= num_rows;
            rows_issued_q <= '0;
            keep_q        <= keep_d;
        end else if (issue) begin
            rd_addr_q     <= (rd_addr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
            rows_issued_q <= rows_issued_q + ROW_W'(1);
        end
    end

    // Tracks each read until its data is valid on obuf_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    // Two-entry FIFO: head drives the stream directly, tail holds the overflow row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_vld_q  <= 1'b0;
            head_data_q <= '0;
            head_keep_q <= '0;
            head_last_q <= 1'b0;
            tail_vld_q  <= 1'b0;
            tail_data_q <= '0;
            tail_keep_q <= '0;
            tail_last_q <= 1'b0;
        end else if (pop) begin
            if (tail_vld_q) begin
                head_data_q <= tail_data_q;
                head_keep_q <= tail_keep_q;
                head_last_q <= tail_last_q;
                if (push) begin
                    tail_data_q <= push_data;
                    tail_keep_q <= keep_q;
                    tail_last_q <= push_last;
                end else begin
                    tail_vld_q <= 1'b0;
                end
            end else if (push) begin
                head_data_q <= push_data;
                head_keep_q <= keep_q;
                head_last_q <= push_last;
            end else begin
                head_vld_q <= 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_q  <= 1'b1;
                head_data_q <= push_data;
                head_keep_q <= keep_q;
                head_last_q <= push_last;
            end else begin
                tail_vld_q  <= 1'b1;
                tail_data_q <= push_data;
                tail_keep_q <= keep_q;
                tail_last_q <= push_last;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && !pop && tail_vld_q));

    assign obuf_read_addr  = rd_addr_q;
    assign ostrm.out_data  = head_data_q;
    assign ostrm.out_keep  = head_keep_q;
    assign ostrm.out_valid = head_vld_q;
    assign ostrm.out_last  = head_last_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Bench for obuf_drain_ctrl: a row-level scoreboard checks every stream beat, busy and done,
// with directed drains and a few hand-computed literals pinning data, timing and wrap.
module tb_obuf_drain_ctrl;
    localparam int unsigned RAM_SIZE   = 256;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned ARRAY_M    = 8;
    localparam int unsigned ACT_WIDTH  = 8;
    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned DATA_W     = ACT_WIDTH * ARRAY_M;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ARRAY_M-1:0] keep;
        logic               last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [ADDR_WIDTH:0]   num_rows = '0;
    logic [3:0]            num_cols = '0;
    logic [ADDR_WIDTH-1:0] obuf_read_addr;
    logic [DATA_W-1:0]     obuf_data;
    logic                  busy, done;
    logic [DATA_W-1:0]     rd_pipe [RD_LATENCY];

    int tests_run = 0;
    int tests_failed = 0;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] log_data[$];
    logic [ARRAY_M-1:0] log_keep[$];
    logic              log_last[$];
    bit                busy_nx = 1'b0;
    bit                done_nx = 1'b0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    obuf_drain_ctrl_if #(.ACT_WIDTH(ACT_WIDTH), .ARRAY_M(ARRAY_M)) ostrm ();

    obuf_drain_ctrl #(
        .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .ARRAY_M(ARRAY_M),
        .ACT_WIDTH(ACT_WIDTH), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .num_cols(num_cols), .obuf_read_addr(obuf_read_addr),
        .obuf_data(obuf_data), .ostrm(ostrm), .busy(busy), .done(done)
    );

    // O buffer contents: column m of row a holds a ^ (m*0x11)
    function automatic logic [7:0] mem_byte(input int unsigned a, input int unsigned m);
        return 8'(a ^ (m * 17));
    endfunction

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_W-1:0] w;
        for (int m = 0; m < ARRAY_M; m++) w[m*8 +: 8] = mem_byte(int'(a), m);
        return w;
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= mem_word(obuf_read_addr);
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign obuf_data = rd_pipe[RD_LATENCY-1];

    function automatic beat_t model_beat(input int base, input int k, input int rows, input int cols);
        beat_t b;
        int unsigned addr;
        addr = (base + k) % RAM_SIZE;
        b.data = '0;
        b.keep = '0;
        for (int m = 0; m < ARRAY_M; m++) begin
            if (m < cols) begin
                b.data[m*8 +: 8] = mem_byte(addr, m);
                b.keep[m] = 1'b1;
            end
        end
        b.last = (k == rows - 1);
        return b;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs are stable at the falling edge; out_ready is what the next rising edge samples
    always @(negedge clk) begin
        bit busy_cur;
        if (!reset) begin
            exp_q.delete();
            busy_nx    = 1'b0;
            done_nx    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("busy", DATA_W'(busy), DATA_W'(busy_nx));
            check("done", DATA_W'(done), DATA_W'(done_nx));
            busy_cur = busy_nx;
            done_nx  = 1'b0;
            if (prev_stall) begin
                check("stall_valid", DATA_W'(ostrm.out_valid), DATA_W'(1));
                check("stall_data", ostrm.out_data, prev_data);
            end
            if (ostrm.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", DATA_W'(ostrm.out_valid), DATA_W'(0));
                end else begin
                    check("beat_data", ostrm.out_data, exp_q[0].data);
                    check("beat_keep", DATA_W'(ostrm.out_keep), DATA_W'(exp_q[0].keep));
                    check("beat_last", DATA_W'(ostrm.out_last), DATA_W'(exp_q[0].last));
                    if (ostrm.out_ready) begin
                        log_data.push_back(ostrm.out_data);
                        log_keep.push_back(ostrm.out_keep);
                        log_last.push_back(ostrm.out_last);
                        if (exp_q[0].last) begin
                            done_nx = 1'b1;
                            busy_nx = 1'b0;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = ostrm.out_valid && !ostrm.out_ready;
            prev_data  = ostrm.out_data;
            if (start && !busy_cur) begin
                if (num_rows == '0) begin
                    done_nx = 1'b1;
                end else begin
                    busy_nx = 1'b1;
                    for (int k = 0; k < int'(num_rows); k++)
                        exp_q.push_back(model_beat(int'(base_addr), k, int'(num_rows), int'(num_cols)));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int base, input int rows, input int cols);
        tick();
        start     = 1'b1;
        base_addr = ADDR_WIDTH'(base);
        num_rows  = (ADDR_WIDTH+1)'(rows);
        num_cols  = 4'(cols);
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_keep.delete();
        log_last.delete();
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            #1;
            idle = (exp_q.size() == 0) && !busy_nx && !done_nx && !ostrm.out_valid;
        end
        check(name, DATA_W'(idle), DATA_W'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, DATA_W'(ostrm.out_valid), '0);
        check({tag, "_data"}, ostrm.out_data, '0);
        check({tag, "_keep"}, DATA_W'(ostrm.out_keep), '0);
        check({tag, "_last"}, DATA_W'(ostrm.out_last), '0);
        check({tag, "_busy"}, DATA_W'(busy), '0);
        check({tag, "_done"}, DATA_W'(done), '0);
        check({tag, "_addr"}, DATA_W'(obuf_read_addr), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, done_idx;
        ostrm.out_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) tick();

        // T1: four full rows, ready held high; pin first-beat and done timing
        clear_log();
        pulse_start(8'h10, 4, 8);
        first_v  = 0;
        done_idx = 0;
        for (int idx = 1; idx <= 30 && done_idx == 0; idx++) begin
            @(negedge clk);
            if (ostrm.out_valid && first_v == 0) first_v = idx;
            if (done) done_idx = idx;
        end
        check("t1_first_valid_cycle", DATA_W'(first_v), DATA_W'(3));
        check("t1_done_cycle", DATA_W'(done_idx), DATA_W'(7));
        wait_idle("t1_idle");
        check("t1_beats", DATA_W'(log_data.size()), DATA_W'(4));
        check("t1_data0", log_data[0], 64'h6776455423320110);
        check("t1_keep0", DATA_W'(log_keep[0]), DATA_W'(8'hFF));
        check("t1_last0", DATA_W'(log_last[0]), DATA_W'(0));
        check("t1_last3", DATA_W'(log_last[3]), DATA_W'(1));

        // T2: five columns, upper bytes forced to zero
        clear_log();
        pulse_start(8'h20, 3, 5);
        wait_idle("t2_idle");
        check("t2_beats", DATA_W'(log_data.size()), DATA_W'(3));
        check("t2_data0", log_data[0], 64'h0000006413023120);
        check("t2_keep0", DATA_W'(log_keep[0]), DATA_W'(8'h1F));

        // T3: address wrap 0xFE,0xFF,0x00,0x01
        clear_log();
        pulse_start(8'hFE, 4, 8);
        wait_idle("t3_idle");
        check("t3_beats", DATA_W'(log_data.size()), DATA_W'(4));
        check("t3_data1", log_data[1], 64'h8899AABBCCDDEEFF);
        check("t3_data2", log_data[2], 64'h7766554433221100);

        // T4: toggling ready with a 5-cycle stall
        clear_log();
        pulse_start(8'h50, 8, 8);
        for (int i = 0; i < 40; i++) begin
            ostrm.out_ready = (i >= 6 && i <= 10) ? 1'b0 : ((i % 2) == 0);
            tick();
        end
        ostrm.out_ready = 1'b1;
        wait_idle("t4_idle");
        check("t4_beats", DATA_W'(log_data.size()), DATA_W'(8));

        // T5: zero-row drain, then a start while busy is ignored
        clear_log();
        pulse_start(8'h00, 0, 8);
        @(negedge clk);
        check("t5_done_pulse", DATA_W'(done), DATA_W'(1));
        check("t5_busy_low", DATA_W'(busy), DATA_W'(0));
        @(negedge clk);
        check("t5_done_single", DATA_W'(done), DATA_W'(0));
        pulse_start(8'h40, 3, 8);
        pulse_start(8'h80, 5, 8);
        wait_idle("t5_idle");
        check("t5_beats", DATA_W'(log_data.size()), DATA_W'(3));
        check("t5_data0", log_data[0], 64'h3726150473625140);

        // T6: reset during a six-row drain, then a clean two-row drain
        clear_log();
        pulse_start(8'h60, 6, 8);
        for (int i = 0; i < 50 && log_data.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_reached_beat2", DATA_W'(log_data.size()), DATA_W'(2));
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        clear_log();
        pulse_start(8'h30, 2, 8);
        wait_idle("t6_idle");
        check("t6_beats", DATA_W'(log_data.size()), DATA_W'(2));
        check("t6_last1", DATA_W'(log_last[1]), DATA_W'(1));

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
